button_event_decoder: RTL and testbench



---
 rtl/button_event_decoder.sv | 188 ++++++++++++++++++
 tb/tb_button_event_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Turns a clean, debounced button level into single-cycle user events.
// Edge pulses are produced unconditionally. A small FSM with one shared
// counter classifies each press as short, long or double.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   din          in   debounced button level, synchronous to clk
//   enable       in   press classification enable (edge pulses ignore it)
//   rise_pulse   out  one-cycle pulse on din 0->1
//   fall_pulse   out  one-cycle pulse on din 1->0
//   short_press  out  one-cycle pulse, press that was neither long nor double
//   long_press   out  one-cycle pulse when the hold reaches LONG_CYCLES
//   double_press out  one-cycle pulse on release of the second press
//   held         out  level, high while in the long-hold state
//   busy         out  level, high whenever the FSM is not idle
//
// All outputs are registered and clear asynchronously on reset.
// -----------------------------------------------------------------------------
module button_event_decoder #(
  parameter int LONG_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 30_000_000,
  parameter int CNT_W       = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic enable,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held,
  output logic busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT_GAP  = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HOLD = 3'd4
  } state_e;

  // Terminal counts: the counter starts at 0 on entry, so maturity is N-1.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             din_q;
  logic             rise_s, fall_s;
  logic             short_d, long_d, double_d;

  logic rise_pulse_q, fall_pulse_q, short_q, long_q, double_q, held_q, busy_q;

  assign rise_s = din & ~din_q;
  assign fall_s = ~din & din_q;

  // Next-state, counter and event decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    if (!enable) begin
      // Classification disabled: abandon any press in progress silently.
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = CNT_ZERO;
          if (rise_s) begin
            state_d = ST_PRESS1;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_PRESS1: begin
          // din_q is always 1 here, so din=0 is exactly a fall. Checking the
          // release first lets a fall on the maturing edge win over long.
          if (!din) begin
            state_d = ST_WAIT_GAP;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = ST_LONG_HOLD;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_WAIT_GAP: begin
          // A second press on the timeout edge still counts as a double.
          if (rise_s) begin
            state_d = ST_PRESS2;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == GAP_LAST) begin
            short_d = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_PRESS2: begin
          cnt_d = CNT_ZERO;
          if (!din) begin
            double_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_PRESS2;
          end
        end

        ST_LONG_HOLD: begin
          cnt_d = CNT_ZERO;
          if (!din) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LONG_HOLD;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state, counter and input history registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      din_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din;
    end
  end

  // Registered event and status outputs; status follows the next state so it
  // lines up with the event pulse that caused the transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
      double_q     <= 1'b0;
      held_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rise_pulse_q <= rise_s;
      fall_pulse_q <= fall_s;
      short_q      <= short_d;
      long_q       <= long_d;
      double_q     <= double_d;
      held_q       <= (state_d == ST_LONG_HOLD);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign rise_pulse   = rise_pulse_q;
  assign fall_pulse   = fall_pulse_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign held         = held_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//
// Drives button_event_decoder (LONG=8, GAP=4, CNT_W=4) with directed and
// random din waveforms. Expected outputs come from a press-level model: the
// waveform is split into high runs (rise edge r, fall edge f) and each press
// is classified from run length and the gap to the next run.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int GAP  = 4;
  localparam int MAXN = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic din = 1'b0;
  logic enable = 1'b1;
  logic rise_pulse, fall_pulse, short_press, long_press, double_press, held, busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Waveform: w[t] is the din value sampled at edge t after reset release.
  bit w [MAXN];
  int n;
  // Expected outputs in the cycle after edge t.
  bit e_rise [MAXN], e_fall [MAXN], e_short [MAXN], e_long [MAXN];
  bit e_dbl [MAXN], e_held [MAXN], e_busy [MAXN];
  int rs [MAXN], fs [MAXN];

  button_event_decoder #(
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (din),
    .enable      (enable),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .held        (held),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int t, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s @%0d: observed %b expected %b", tag, t, obs, expv);
  endtask

  task automatic chk_all(input string tag, input int t,
                         input bit r, input bit f, input bit s, input bit l,
                         input bit d, input bit h, input bit b);
    chk({tag, ".rise"},   t, rise_pulse,   r);
    chk({tag, ".fall"},   t, fall_pulse,   f);
    chk({tag, ".short"},  t, short_press,  s);
    chk({tag, ".long"},   t, long_press,   l);
    chk({tag, ".double"}, t, double_press, d);
    chk({tag, ".held"},   t, held,         h);
    chk({tag, ".busy"},   t, busy,         b);
  endtask

  // Assert reset with din toggling; outputs must be 0 throughout.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    enable  = 1'b1;
    #1;
    chk_all("rst_async", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      din = ~din;
      @(posedge clk);
      #1;
      chk_all("rst_hold", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic step(input logic d, input logic en);
    @(negedge clk);
    din    = d;
    enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic add_seg(input bit val, input int len);
    for (int k = 0; k < len; k++) begin
      if (n < MAXN) begin
        w[n] = val;
        n++;
      end
    end
  endtask

  // Press-level reference model.
  task automatic build_expect();
    int np, i, r, f;
    bit prev;
    for (int t = 0; t < MAXN; t++) begin
      e_rise[t] = 0; e_fall[t] = 0; e_short[t] = 0; e_long[t] = 0;
      e_dbl[t] = 0; e_held[t] = 0; e_busy[t] = 0;
    end
    prev = 1'b0;
    np = 0;
    for (int t = 0; t < n; t++) begin
      if (w[t] && !prev) begin
        e_rise[t] = 1;
        rs[np] = t;
      end
      if (!w[t] && prev) begin
        e_fall[t] = 1;
        fs[np] = t;
        np++;
      end
      prev = w[t];
    end
    i = 0;
    while (i < np) begin
      r = rs[i];
      f = fs[i];
      if (f - r > LONG) begin
        e_long[r + LONG] = 1;
        for (int t = r; t < f; t++) e_busy[t] = 1;
        for (int t = r + LONG; t < f; t++) e_held[t] = 1;
        i++;
      end else if (i + 1 < np && rs[i+1] - f <= GAP) begin
        e_dbl[fs[i+1]] = 1;
        for (int t = r; t < fs[i+1]; t++) e_busy[t] = 1;
        i += 2;
      end else begin
        e_short[f + GAP] = 1;
        for (int t = r; t < f + GAP; t++) e_busy[t] = 1;
        i++;
      end
    end
  endtask

  // Reset, then play w[0..n-1] from reset release and compare every cycle.
  task automatic run_wave(input string tag);
    add_seg(1'b0, GAP + 4);
    build_expect();
    do_reset();
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (t == 0) reset_n = 1'b1;
      din = w[t];
      @(posedge clk);
      #1;
      chk_all(tag, t, e_rise[t], e_fall[t], e_short[t], e_long[t],
              e_dbl[t], e_held[t], e_busy[t]);
    end
  endtask

  initial begin
    // Reset with din=1 at release, then a short press.
    n = 0; add_seg(1'b1, 3); add_seg(1'b0, 6);
    run_wave("short");

    // Long press held for 12 samples.
    n = 0; add_seg(1'b1, 12);
    run_wave("long");

    // Double press with a 4-sample gap (boundary, qualifies).
    n = 0; add_seg(1'b1, 2); add_seg(1'b0, 4); add_seg(1'b1, 2);
    run_wave("dbl_gap4");

    // 5-sample gap: short press then a fresh short press.
    n = 0; add_seg(1'b1, 2); add_seg(1'b0, 5); add_seg(1'b1, 2);
    run_wave("dbl_gap5");

    // Exactly 8 high samples: release wins over long.
    n = 0; add_seg(1'b0, 1); add_seg(1'b1, 8);
    run_wave("long_edge");

    // enable=0 for one cycle mid-press: silent abort, edges still reported.
    do_reset();
    @(negedge clk);
    reset_n = 1'b1;
    din = 1'b0;
    step(1'b1, 1'b1);
    chk_all("en_rise", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk_all("en_hold", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk_all("en_off", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk_all("en_back", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk_all("en_fall", 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1);
      chk_all("en_quiet", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset pulse during the gap: no pending short press.
    do_reset();
    @(negedge clk);
    reset_n = 1'b1;
    din = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk_all("rg_fall", 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_all("rg_gap", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_all("rg_async", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1);
      chk_all("rg_quiet", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Random press trains around the long and gap boundaries.
    for (int run = 0; run < 8; run++) begin
      n = 0;
      add_seg(1'b0, $urandom_range(0, 3));
      while (n < 150) begin
        add_seg(1'b1, $urandom_range(1, 12));
        add_seg(1'b0, $urandom_range(1, 7));
      end
      run_wave("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
